if_pc_stage: RTL and testbench
==============================

// Module: if_pc_stage
// PURPOSE
//  Instruction-fetch / PC stage of the multi-cycle MIPS core, directly upstream of the control unit.
//  Holds the PC and fetches one instruction over a req/ack instruction-memory interface.
//  Latches the instruction into an IR and presents opcode/funct to the control unit.
//  Consumes the control unit's NPCSel, the extended immediate and the rs value to form the next PC.
// PARAMETERS
//  RESET_PC     32'h0000_3000  PC value loaded on reset
//  ACK_TIMEOUT  16             max cycles imem_req may wait for imem_ack before fetch_err
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  npc_sel      in   2   00 PC+4, 01 branch, 10 jump (j/jal), 11 register (jr/jalr)
//  ext_imm      in   32  sign-extended 16-bit immediate from the extender
//  rs_data      in   32  GPR[rs], used as the jr/jalr target
//  stall        in   1   hold the current instruction in EXEC (no PC commit)
//  imem_req     out  1   fetch request, held high until ack
//  imem_addr    out  32  fetch byte address, equal to pc while imem_req is high
//  imem_ack     in   1   one-cycle pulse: imem_rdata valid this cycle
//  imem_rdata   in   32  fetched instruction word
//  pc           out  32  address of the instruction in IR
//  pc_plus4     out  32  pc+4 (jal/jalr link value)
//  instr        out  32  instruction register
//  opcode       out  6   instr[31:26]
//  funct        out  6   instr[5:0]
//  instr_valid  out  1   high in EXEC: instr/opcode/funct are valid for decode
//  misalign     out  1   one-cycle pulse: jr target had addr[1:0]!=0
//  fetch_err    out  1   sticky: ack not received within ACK_TIMEOUT cycles
// BEHAVIOUR
//  Reset (async, any state): pc=RESET_PC, instr=0, state=FETCH, timeout count=0.
//   Outputs on reset: imem_req=0, instr_valid=0, misalign=0, fetch_err=0.
//   On the first clk after rst falls, the block enters FETCH with imem_req=1.
//  Three states: FETCH, EXEC, ERR.
//  FETCH:
//   - imem_req=1 and imem_addr=pc.
//   - On imem_ack: instr<=imem_rdata, timeout count cleared, go to EXEC next cycle.
//   - Otherwise the timeout count increments. When it reaches ACK_TIMEOUT: go to ERR,
//     fetch_err<=1, imem_req drops.
//  EXEC:
//   - instr_valid=1 and imem_req=0. Any imem_ack seen in EXEC is ignored.
//   - stall=1: hold; pc and instr are unchanged.
//   - stall=0: pc<=npc, go to FETCH. One instruction is retired per EXEC exit.
//  ERR: terminal state. Only rst leaves it. imem_req=0, instr_valid=0.
//  npc is combinational from the registered pc and instr:
//   - 00: pc+4
//   - 01: pc+4 + (ext_imm<<2)
//   - 10: {pc_plus4[31:28], instr[25:0], 2'b00}
//   - 11: {rs_data[31:2], 2'b00}
//  32-bit modular arithmetic; wrap past 32'hFFFF_FFFC is not flagged.
//  misalign: pulses in the EXEC exit cycle when npc_sel=11 and rs_data[1:0]!=0.
//   The committed target is still forced word-aligned.
//  npc_sel, ext_imm and rs_data are sampled only in the EXEC exit cycle.
//   Values present in FETCH have no effect.
//  Latency: minimum 2 cycles per instruction (ack in the first FETCH cycle, no stall).
//  Reset mid-fetch abandons the request. A late ack after reset, before the new request,
//   is ignored because the block is not in FETCH.
// TESTING
//  T1: release rst; ack in 1st FETCH cycle with 0x20080005 -> imem_addr=0x3000,
//      instr_valid next cycle, opcode=0x08.
//  T2: EXEC with npc_sel=00, then 01 and ext_imm=0xFFFFFFFF at pc=0x3004
//      -> pc=0x3004, then next pc=0x3004.
//  T3: instr=0x08000C10 (j), npc_sel=10, pc=0x3000 -> next pc=0x00003040.
//  T4: npc_sel=11, rs_data=0x3013 -> pc=0x3010, misalign pulses exactly 1 cycle.
//  T5: stall=1 for 3 EXEC cycles -> pc/instr unchanged, instr_valid stays 1;
//      commit after stall=0.
//  T6: withhold ack for 16 cycles -> fetch_err=1 in ERR, imem_req=0;
//      assert rst -> fetch_err=0, pc=0x3000.

Source files
------------

// File: rtl/if_pc_stage.sv
// if_pc_stage: holds the PC, fetches one instruction over req/ack into IR and commits the next PC on EXEC exit
module if_pc_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_3000,
   parameter int          ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  npc_sel,
   input  logic [31:0] ext_imm,
   input  logic [31:0] rs_data,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic        instr_valid,
   output logic        misalign,
   output logic        fetch_err
);
   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [1:0] FETCH = 2'd0, EXEC = 2'd1, ERR = 2'd2;
   logic [1:0]    state;
   logic          run;
   logic [CW-1:0] cnt;
   logic [31:0]   npc;
   logic          exit_exec;
   // run keeps imem_req low until the first clock after reset is released
   assign imem_req    = run && state == FETCH;
   assign imem_addr   = pc;
   assign pc_plus4    = pc + 32'd4;
   assign opcode      = instr[31:26];
   assign funct       = instr[5:0];
   assign instr_valid = state == EXEC;
   assign fetch_err   = state == ERR;
   assign exit_exec   = instr_valid && !stall;
   assign misalign    = exit_exec && npc_sel == 2'b11 && |rs_data[1:0];
   always_comb
      npc = npc_sel == 2'b00 ? pc_plus4 :
            npc_sel == 2'b01 ? pc_plus4 + {ext_imm[29:0], 2'b00} :
            npc_sel == 2'b10 ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                               {rs_data[31:2], 2'b00};
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= FETCH;
         run   <= 1'b0;
         cnt   <= '0;
         pc    <= RESET_PC;
         instr <= '0;
      end else begin
         run <= 1'b1;
         if (imem_req) begin
            if (imem_ack) begin
               instr <= imem_rdata;
               cnt   <= '0;
               state <= EXEC;
            end else if (cnt == CW'(ACK_TIMEOUT - 1))
               state <= ERR;
            else
               cnt <= cnt + 1'b1;
         end else if (exit_exec) begin
            pc    <= npc;
            state <= FETCH;
         end
      end
endmodule

// File: tb/tb_if_pc_stage.sv
// tb_if_pc_stage: randomized fetch/exec traffic checked against a transaction-level PC model
module tb_if_pc_stage;
   logic        clk = 0, rst = 1;
   logic [1:0]  npc_sel = 0;
   logic [31:0] ext_imm = 0, rs_data = 0, imem_rdata = 0;
   logic        stall = 0, imem_ack = 0;
   logic        imem_req, instr_valid, misalign, fetch_err;
   logic [31:0] imem_addr, pc, pc_plus4, instr;
   logic [5:0]  opcode, funct;
   int errors = 0, checks = 0;
   logic [31:0] mpc, w, nxt;
   logic [1:0]  sel;
   logic [31:0] imm, rsd;

   if_pc_stage dut (
      .clk(clk), .rst(rst), .npc_sel(npc_sel), .ext_imm(ext_imm), .rs_data(rs_data),
      .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .pc(pc), .pc_plus4(pc_plus4), .instr(instr),
      .opcode(opcode), .funct(funct), .instr_valid(instr_valid), .misalign(misalign),
      .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one full instruction: fetch with ack delay d, k stall cycles, then exit with given controls
   task automatic run_instr(input logic [31:0] word, input int d, input int k,
                            input logic [1:0] s, input logic [31:0] im, input logic [31:0] rv);
      chk("req", {31'd0, imem_req}, 32'd1);
      chk("addr", imem_addr, mpc);
      for (int i = 0; i < d; i++) begin
         npc_sel = 2'($urandom);
         ext_imm = $urandom;
         rs_data = $urandom;
         tick();
         chk("req_wait", {31'd0, imem_req}, 32'd1);
      end
      imem_ack = 1;
      imem_rdata = word;
      tick();
      imem_ack = 0;
      imem_rdata = $urandom;
      chk("valid", {31'd0, instr_valid}, 32'd1);
      chk("req_exec", {31'd0, imem_req}, 32'd0);
      chk("instr", instr, word);
      chk("opcode", {26'd0, opcode}, {26'd0, word[31:26]});
      chk("funct", {26'd0, funct}, {26'd0, word[5:0]});
      chk("pc", pc, mpc);
      chk("pc_plus4", pc_plus4, mpc + 4);
      for (int i = 0; i < k; i++) begin
         stall = 1;
         npc_sel = 2'b11;
         rs_data = 32'h3;
         imem_ack = 1;
         #1;
         chk("mis_stall", {31'd0, misalign}, 32'd0);
         tick();
         imem_ack = 0;
         chk("stall_pc", pc, mpc);
         chk("stall_instr", instr, word);
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      end
      stall = 0;
      npc_sel = s;
      ext_imm = im;
      rs_data = rv;
      #1;
      chk("misalign", {31'd0, misalign}, {31'd0, s == 2'b11 && rv % 4 != 0});
      case (s)
         2'b00: nxt = mpc + 4;
         2'b01: nxt = mpc + 4 + im * 4;
         2'b10: nxt = ((mpc + 4) & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
         default: nxt = rv - rv % 4;
      endcase
      tick();
      mpc = nxt;
      chk("mis_after", {31'd0, misalign}, 32'd0);
      chk("next_pc", pc, mpc);
   endtask

   initial begin
      #12;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_pc", pc, 32'h3000);
      chk("rst_instr", instr, 32'd0);
      chk("rst_err", {31'd0, fetch_err}, 32'd0);
      chk("rst_mis", {31'd0, misalign}, 32'd0);
      @(posedge clk);
      #1 rst = 0;
      chk("pre_req", {31'd0, imem_req}, 32'd0);
      tick();
      mpc = 32'h3000;
      // directed sequence: addi, pc+4, branch -1, jump, jr misaligned
      run_instr(32'h2008_0005, 0, 0, 2'b00, 0, 0);
      run_instr($urandom, 0, 0, 2'b01, 32'hFFFF_FFFF, 0);
      chk("t2_pc", pc, 32'h3004);
      run_instr(32'h0800_0C10, 1, 3, 2'b10, 0, 0);
      chk("t3_pc", pc, 32'h0000_3040);
      run_instr($urandom, 0, 0, 2'b11, 0, 32'h3013);
      chk("t4_pc", pc, 32'h3010);
      for (int n = 0; n < 60; n++) begin
         sel = 2'($urandom);
         imm = $urandom;
         rsd = $urandom;
         if (n % 7 == 0) rsd = 32'hFFFF_FFFD;
         if (n % 5 == 0) imm = {{16{1'b1}}, 16'($urandom)};
         run_instr($urandom, $urandom_range(0, 5), $urandom_range(0, 2), sel, imm, rsd);
      end
      // withheld ack: 15 cycles still fetching, 16th enters ERR
      for (int i = 0; i < 15; i++) tick();
      chk("to_req15", {31'd0, imem_req}, 32'd1);
      chk("to_err15", {31'd0, fetch_err}, 32'd0);
      tick();
      chk("to_err", {31'd0, fetch_err}, 32'd1);
      chk("to_req", {31'd0, imem_req}, 32'd0);
      chk("to_valid", {31'd0, instr_valid}, 32'd0);
      w = instr;
      imem_ack = 1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 0;
      chk("err_sticky", {31'd0, fetch_err}, 32'd1);
      chk("err_instr", instr, w);
      rst = 1;
      #1;
      chk("rerst_err", {31'd0, fetch_err}, 32'd0);
      chk("rerst_pc", pc, 32'h3000);
      chk("rerst_req", {31'd0, imem_req}, 32'd0);
      @(posedge clk);
      #1 rst = 0;
      imem_ack = 1;
      imem_rdata = 32'h1234_5678;
      tick();
      imem_ack = 0;
      chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
      chk("late_ack_instr", instr, 32'd0);
      mpc = 32'h3000;
      run_instr(32'h0000_0008, 0, 0, 2'b00, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
